// File: rtl/ex_muldiv_unit_pkg.sv
// +------------------------------------------------------------------+
// | mips_md_pkg : op codes, FSM states, divide-by-zero fill constant  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package mips_md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Bit replicated across LO when the divisor is zero
  localparam logic DZ_LO_BIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
// +------------------------------------------------------------------+
// | ex_muldiv_unit_if : request/result bundle of the HI/LO unit       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            cancel;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, cancel,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, cancel,
    output busy, done, div_zero, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_unit_div_iter.sv
// +------------------------------------------------------------------+
// | md_div_iter : unsigned restoring divider, one quotient bit/step   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module md_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;

  // r_rem < r_dvs always holds, so the top bit of w_trial is a pure borrow
  always_comb begin
    w_shift = {r_rem, r_quo[XLEN-1]};
    w_trial = w_shift - {1'b0, r_dvs};
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
    end else if (step) begin
      if (!w_trial[XLEN]) begin
        r_rem <= w_trial[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// +------------------------------------------------------------------+
// | ex_muldiv_unit : multi-cycle MULT/DIV unit owning HI/LO           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module ex_muldiv_unit
  import mips_md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  ex_muldiv_unit_if.slave  bus
);

  localparam int CNT_W      = $clog2(XLEN);
  localparam int c_mul_last = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]  r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic             w_wr_hi, w_wr_lo, w_accept, w_dz_set, w_latch;
  logic             w_div_load, w_div_step;
  logic             r_done, r_dz;
  logic [XLEN-1:0]  r_mul_a, r_mul_b;
  logic             r_mul_sgn, r_neg_q, r_neg_r;
  logic             w_idle, w_op_sdiv, w_rs_neg, w_rt_neg, w_mul_sgn;
  logic [XLEN-1:0]  w_abs_rs, w_abs_rt, w_mul_a, w_mul_b;
  logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_prod;
  logic [XLEN-1:0]  w_quo, w_rem, w_quo_fix, w_rem_fix;

  // Operand preparation; the IDLE path feeds raw operands so MUL_LAT=1 works
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_op_sdiv = (bus.op == MD_DIV);
    w_rs_neg  = bus.rs_val[XLEN-1];
    w_rt_neg  = bus.rt_val[XLEN-1];
    w_abs_rs  = (w_op_sdiv && w_rs_neg) ? -bus.rs_val : bus.rs_val;
    w_abs_rt  = (w_op_sdiv && w_rt_neg) ? -bus.rt_val : bus.rt_val;
    w_mul_sgn = w_idle ? (bus.op == MD_MULT) : r_mul_sgn;
    w_mul_a   = w_idle ? bus.rs_val : r_mul_a;
    w_mul_b   = w_idle ? bus.rt_val : r_mul_b;
    w_ext_a   = {{XLEN{w_mul_sgn & w_mul_a[XLEN-1]}}, w_mul_a};
    w_ext_b   = {{XLEN{w_mul_sgn & w_mul_b[XLEN-1]}}, w_mul_b};
    w_prod    = w_ext_a * w_ext_b;
    w_quo_fix = r_neg_q ? -w_quo : w_quo;
    w_rem_fix = r_neg_r ? -w_rem : w_rem;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_wr_hi     = 1'b0;
    w_wr_lo     = 1'b0;
    w_accept    = 1'b0;
    w_dz_set    = 1'b0;
    w_latch     = 1'b0;
    w_div_load  = 1'b0;
    w_div_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_cnt_nxt = '0;
          case (bus.op)
            MD_MTHI: begin
              w_accept = 1'b1;
              w_wr_hi  = 1'b1;
              w_hi_nxt = bus.rs_val;
            end
            MD_MTLO: begin
              w_accept = 1'b1;
              w_wr_lo  = 1'b1;
              w_lo_nxt = bus.rs_val;
            end
            MD_MULT, MD_MULTU: begin
              w_accept = 1'b1;
              if (MUL_LAT == 1) begin
                w_wr_hi  = 1'b1;
                w_wr_lo  = 1'b1;
                w_hi_nxt = w_prod[2*XLEN-1:XLEN];
                w_lo_nxt = w_prod[XLEN-1:0];
              end else begin
                w_latch     = 1'b1;
                w_state_nxt = ST_MUL;
              end
            end
            MD_DIV, MD_DIVU: begin
              w_accept = 1'b1;
              if (bus.rt_val == '0) begin
                w_dz_set = 1'b1;
                w_wr_hi  = 1'b1;
                w_wr_lo  = 1'b1;
                w_hi_nxt = bus.rs_val;
                w_lo_nxt = {XLEN{DZ_LO_BIT}};
              end else begin
                w_latch     = 1'b1;
                w_div_load  = 1'b1;
                w_state_nxt = ST_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (bus.cancel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(c_mul_last)) begin
          w_wr_hi     = 1'b1;
          w_wr_lo     = 1'b1;
          w_hi_nxt    = w_prod[2*XLEN-1:XLEN];
          w_lo_nxt    = w_prod[XLEN-1:0];
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DIV: begin
        if (bus.cancel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_div_step = 1'b1;
          if (r_cnt == CNT_W'(XLEN - 1)) begin
            w_state_nxt = ST_FIX;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        if (!bus.cancel) begin
          w_wr_hi  = 1'b1;
          w_wr_lo  = 1'b1;
          w_hi_nxt = w_rem_fix;
          w_lo_nxt = w_quo_fix;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      if (w_wr_hi) r_hi <= w_hi_nxt;
      if (w_wr_lo) r_lo <= w_lo_nxt;
      r_done <= w_wr_hi | w_wr_lo;
      if (w_accept) r_dz <= w_dz_set;
    end
  end

  // Signs are resolved at accept time so the divider core stays unsigned
  always_ff @(posedge CLK) begin
    if (w_latch) begin
      r_mul_a   <= bus.rs_val;
      r_mul_b   <= bus.rt_val;
      r_mul_sgn <= (bus.op == MD_MULT);
      r_neg_q   <= w_op_sdiv & (w_rs_neg ^ w_rt_neg);
      r_neg_r   <= w_op_sdiv & w_rs_neg;
    end
  end

  md_div_iter #(.XLEN(XLEN)) u_div (
    .CLK       (CLK),
    .load      (w_div_load),
    .step      (w_div_step),
    .dividend  (w_abs_rs),
    .divisor   (w_abs_rt),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// +------------------------------------------------------------------+
// | tb_ex_muldiv_unit : directed vectors for the HI/LO unit           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ex_muldiv_unit;
  import mips_md_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n;

  always #5 CLK = ~CLK;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32), .MUL_LAT(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Holds start for exactly one rising edge; returns at the next negedge (cycle 1)
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    @(negedge CLK);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < limit) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = MD_MULT;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.cancel = 1'b0;
    RST        = 1'b1;
    repeat (3) @(negedge CLK);
    chk_val("rst_hi",   bus.hi, 32'h0);
    chk_val("rst_lo",   bus.lo, 32'h0);
    chk_val("rst_busy", 32'(bus.busy), 32'h0);
    chk_val("rst_done", 32'(bus.done), 32'h0);
    chk_val("rst_dz",   32'(bus.div_zero), 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    chk_val("mult_busy", 32'(bus.busy), 32'h1);
    wait_done(10, n);
    chk_val("mult_lat", 32'(n), 32'd3);
    chk_val("mult_hi",  bus.hi, 32'hFFFF_FFFF);
    chk_val("mult_lo",  bus.lo, 32'hFFFF_FFEB);
    @(negedge CLK);
    chk_val("mult_done_pulse", 32'(bus.done), 32'h0);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(10, n);
    chk_val("multu_lat", 32'(n), 32'd3);
    chk_val("multu_hi",  bus.hi, 32'h0000_0001);
    chk_val("multu_lo",  bus.lo, 32'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk_val("div_busy_cycles", 32'(n), 32'd33);
    chk_val("div_done", 32'(bus.done), 32'h1);
    chk_val("div_lo",   bus.lo, 32'hFFFF_FFFD);
    chk_val("div_hi",   bus.hi, 32'hFFFF_FFFF);

    issue(MD_DIVU, 32'd7, 32'd0);
    chk_val("dz_done", 32'(bus.done), 32'h1);
    chk_val("dz_busy", 32'(bus.busy), 32'h0);
    chk_val("dz_lo",   bus.lo, 32'hFFFF_FFFF);
    chk_val("dz_hi",   bus.hi, 32'h0000_0007);
    chk_val("dz_flag", 32'(bus.div_zero), 32'h1);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk_val("ovf_dz_clr", 32'(bus.div_zero), 32'h0);
    wait_done(50, n);
    chk_val("ovf_lat", 32'(n), 32'd34);
    chk_val("ovf_lo",  bus.lo, 32'h8000_0000);
    chk_val("ovf_hi",  bus.hi, 32'h0000_0000);

    // Cancel a divide mid-flight; a start while busy must be dropped
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (3) @(negedge CLK);
    bus.start  = 1'b1;
    bus.op     = MD_MTLO;
    bus.rs_val = 32'd9;
    @(negedge CLK);
    bus.start  = 1'b0;
    chk_val("cxl_busy", 32'(bus.busy), 32'h1);
    repeat (5) @(negedge CLK);
    bus.cancel = 1'b1;
    @(negedge CLK);
    bus.cancel = 1'b0;
    chk_val("cxl_idle", 32'(bus.busy), 32'h0);
    chk_val("cxl_done", 32'(bus.done), 32'h0);
    chk_val("cxl_lo",   bus.lo, 32'h8000_0000);
    chk_val("cxl_hi",   bus.hi, 32'h0000_0000);
    issue(MD_MTLO, 32'd5, 32'd0);
    chk_val("mtlo_lo",   bus.lo, 32'h0000_0005);
    chk_val("mtlo_hi",   bus.hi, 32'h0000_0000);
    chk_val("mtlo_done", 32'(bus.done), 32'h1);
    chk_val("mtlo_busy", 32'(bus.busy), 32'h0);

    bus.cancel = 1'b1;
    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    bus.cancel = 1'b0;
    chk_val("mthi_cxl_hi",   bus.hi, 32'h1234_5678);
    chk_val("mthi_cxl_done", 32'(bus.done), 32'h1);

    // Cancel in the final multiply cycle suppresses the write
    issue(MD_MULT, 32'd4, 32'd5);
    @(negedge CLK);
    bus.cancel = 1'b1;
    @(negedge CLK);
    bus.cancel = 1'b0;
    chk_val("mcxl_done", 32'(bus.done), 32'h0);
    chk_val("mcxl_busy", 32'(bus.busy), 32'h0);
    chk_val("mcxl_hi",   bus.hi, 32'h1234_5678);
    chk_val("mcxl_lo",   bus.lo, 32'h0000_0005);

    issue(MD_DIVU, 32'd50, 32'd7);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_val("rmid_busy", 32'(bus.busy), 32'h0);
    chk_val("rmid_hi",   bus.hi, 32'h0);
    chk_val("rmid_lo",   bus.lo, 32'h0);

    issue(MD_DIVU, 32'd50, 32'd7);
    wait_done(50, n);
    chk_val("divu_lo", bus.lo, 32'd7);
    chk_val("divu_hi", bus.hi, 32'd1);

    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(50, n);
    chk_val("divn_lo", bus.lo, 32'hFFFF_FFFD);
    chk_val("divn_hi", bus.hi, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
